// File: rtl/run_check_pkg.sv
// Shared types and constants for the run-length checker: FSM states, mode encodings
// and the detection-counter width.
package run_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ONES   = 2'b00;
  localparam logic [1:0] MODE_ZEROS  = 2'b01;
  localparam logic [1:0] MODE_EITHER = 2'b10;

  localparam int DET_CNT_W = 16;

  // The reserved encoding 2'b11 behaves exactly like MODE_ONES.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_ONES : m;
  endfunction

endpackage

// File: rtl/run_hold_timer.sv
// Loadable down-counter that times the post-detection hold window.
// busy is registered; done flags the enabled cycle that consumes the last count.
module run_hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic         busy_q;

  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      cnt_q  <= value;
      busy_q <= (value != '0);
    end else if (en && busy_q) begin
      cnt_q <= cnt_q - W'(1);
      if (cnt_q == W'(1)) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = en && busy_q && (cnt_q == W'(1));

endmodule

// File: rtl/run_length_checker.sv
// Serial run detector: counts consecutive matching bits and pulses result at THRESH,
// then holds off for HOLD_CYC valid cycles. Define RUN_STATS_EN to add the det_cnt port.
module run_length_checker
  import run_check_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int THRESH   = 8,
  parameter int HOLD_CYC = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_valid,
  input  logic             din,
  input  logic [1:0]       mode,
  output logic             hold,
  output logic [CNT_W-1:0] num_cnt,
`ifdef RUN_STATS_EN
  output logic [DET_CNT_W-1:0] det_cnt,
`endif
  output logic             result
);

  localparam int CNT_MAX = 2**CNT_W - 1;
  localparam int TMR_W   = $clog2(HOLD_CYC + 1);

  if (THRESH < 1 || THRESH > CNT_MAX) begin : g_bad_thresh
    $error("run_length_checker: THRESH must be in 1..2**CNT_W-1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("run_length_checker: HOLD_CYC must be >= 1");
  end

  state_e           state_q;
  logic [1:0]       mode_q;
  logic             last_bit_q;
  logic [CNT_W-1:0] num_cnt_q;
  logic             result_q;

  logic [1:0]       mode_eff;
  logic             match;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_busy;
  logic             tmr_done;

  // mode is only honoured while idle; once a run starts the latched copy rules.
  assign mode_eff = (state_q == IDLE) ? norm_mode(mode) : mode_q;

  always_comb begin
    match = din;
    unique case (mode_eff)
      MODE_ZEROS:  match = !din;
      MODE_EITHER: match = (num_cnt_q == '0) || (din == last_bit_q);
      default:     match = din;
    endcase
  end

  assign cnt_inc  = (num_cnt_q == CNT_W'(CNT_MAX)) ? num_cnt_q : num_cnt_q + CNT_W'(1);
  assign hit      = (cnt_inc == CNT_W'(THRESH));
  assign tmr_load = din_valid && (state_q != HOLD) && match && hit;
  assign tmr_en   = din_valid && (state_q == HOLD);

  run_hold_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .load  (tmr_load),
    .value (TMR_W'(HOLD_CYC)),
    .en    (tmr_en),
    .busy  (tmr_busy),
    .done  (tmr_done)
  );

  // NOTE: reset is synchronous, so it is just the highest-priority branch of the
  // clocked block and must cover every state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ONES;
      last_bit_q <= 1'b0;
      num_cnt_q  <= '0;
      result_q   <= 1'b0;
    end else begin
      result_q <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          IDLE: begin
            if (match) begin
              mode_q     <= norm_mode(mode);
              last_bit_q <= din;
              num_cnt_q  <= cnt_inc;
              if (hit) begin
                result_q <= 1'b1;
                state_q  <= HOLD;
              end else begin
                state_q  <= COUNT;
              end
            end
          end
          COUNT: begin
            if (match) begin
              num_cnt_q <= cnt_inc;
              if (hit) begin
                result_q <= 1'b1;
                state_q  <= HOLD;
              end
            end else if (mode_q == MODE_EITHER) begin
              num_cnt_q  <= CNT_W'(1);
              last_bit_q <= din;
            end else begin
              num_cnt_q <= '0;
              state_q   <= IDLE;
            end
          end
          HOLD: begin
            if (tmr_done) begin
              num_cnt_q <= '0;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef RUN_STATS_EN
  logic [DET_CNT_W-1:0] det_cnt_q;
  logic [DET_CNT_W-1:0] det_cnt_d;

  always_comb begin
    det_cnt_d = det_cnt_q;
    if (tmr_load && (det_cnt_q != {DET_CNT_W{1'b1}})) det_cnt_d = det_cnt_q + DET_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) det_cnt_q <= '0;
    else       det_cnt_q <= det_cnt_d;
  end

  assign det_cnt = det_cnt_q;
`endif

  assign hold    = tmr_busy;
  assign num_cnt = num_cnt_q;
  assign result  = result_q;

endmodule
